// File: rtl/id_hazard_sched_if.sv
// Pipeline <-> hazard scheduler bundle. The master modport belongs to the pipeline side and the slave modport to the scheduler.
// Perf-counter signals exist only when HAZ_SCHED_PERF_CNT_EN is defined.
interface id_hazard_sched_if;
  logic       id_valid;
  logic [3:0] id_rs;
  logic [3:0] id_rt;
  logic       id_uses_rt;
  logic       ex_valid;
  logic       ex_mem_to_reg;
  logic [3:0] ex_rd;
  logic       ctrl_taken;
  logic       mem_busy;

  logic       stall_pc;
  logic       stall_ifid;
  logic       bubble_idex;
  logic       stall_idex;
  logic       stall_exmem;
  logic       flush_ifid;
  logic       flush_idex;
  logic [1:0] sched_state;

`ifdef HAZ_SCHED_PERF_CNT_EN
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rt, ex_valid, ex_mem_to_reg, ex_rd,
           ctrl_taken, mem_busy,
    input  stall_pc, stall_ifid, bubble_idex, stall_idex, stall_exmem,
           flush_ifid, flush_idex, sched_state, stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rt, ex_valid, ex_mem_to_reg, ex_rd,
           ctrl_taken, mem_busy,
    output stall_pc, stall_ifid, bubble_idex, stall_idex, stall_exmem,
           flush_ifid, flush_idex, sched_state, stall_count, flush_count
  );
`else
  modport master (
    output id_valid, id_rs, id_rt, id_uses_rt, ex_valid, ex_mem_to_reg, ex_rd,
           ctrl_taken, mem_busy,
    input  stall_pc, stall_ifid, bubble_idex, stall_idex, stall_exmem,
           flush_ifid, flush_idex, sched_state
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rt, ex_valid, ex_mem_to_reg, ex_rd,
           ctrl_taken, mem_busy,
    output stall_pc, stall_ifid, bubble_idex, stall_idex, stall_exmem,
           flush_ifid, flush_idex, sched_state
  );
`endif
endinterface

// File: rtl/id_hazard_sched.sv
// ID-stage hazard scheduler. It generates the load-use stall, the control-transfer flush and the memory-wait hold.
// Optional feature: define HAZ_SCHED_PERF_CNT_EN to add the saturating stall/flush cycle counters.
module id_hazard_sched #(
  parameter int FLUSH_CYCLES = 2
) (
  input logic              clk,
  input logic              rst_n,
  id_hazard_sched_if.slave bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    MEMWAIT = 2'd2,
    ILLEGAL = 2'd3
  } state_e;

  localparam logic [2:0] RELOAD = (FLUSH_CYCLES > 1) ? 3'(FLUSH_CYCLES - 2) : 3'd0;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       pend_q, pend_d;
  logic       resume_q, resume_d;

  logic hazard;
  logic take_flush;

  assign hazard = bus.id_valid && bus.ex_valid && bus.ex_mem_to_reg && (bus.ex_rd != 4'd0) &&
                  ((bus.ex_rd == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rd == bus.id_rt)));

  // A flush is due for a control transfer in this cycle or for one recorded during a memory wait.
  assign take_flush = bus.ctrl_taken || ((state_q == MEMWAIT) && pend_q);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      cnt_q    <= 3'd0;
      pend_q   <= 1'b0;
      resume_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      resume_q <= resume_d;
    end
  end

  // NOTE: hold defaults are assigned first so no path through this block can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    resume_d = resume_q;
    case (state_q)
      RUN, FLUSH, MEMWAIT: begin
        if (bus.mem_busy) begin
          state_d = MEMWAIT;
          pend_d  = pend_q || bus.ctrl_taken;
          if (state_q == FLUSH)    resume_d = (cnt_q != 3'd0);
          else if (state_q == RUN) resume_d = 1'b0;
        end else if (take_flush) begin
          pend_d   = 1'b0;
          resume_d = 1'b0;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            cnt_d   = RELOAD;
          end else begin
            state_d = RUN;
            cnt_d   = 3'd0;
          end
        end else if (state_q == FLUSH) begin
          if (cnt_q == 3'd0) state_d = RUN;
          else               cnt_d   = cnt_q - 3'd1;
        end else if (state_q == MEMWAIT) begin
          // The frozen counter is reused when an interrupted flush is resumed.
          state_d  = resume_q ? FLUSH : RUN;
          resume_d = 1'b0;
        end
      end
      default: begin
        state_d  = RUN;
        cnt_d    = 3'd0;
        pend_d   = 1'b0;
        resume_d = 1'b0;
      end
    endcase
  end

  logic stall_pc, stall_ifid, bubble_idex, stall_idex, stall_exmem, flush_ifid, flush_idex;

  always_comb begin
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    bubble_idex = 1'b0;
    stall_idex  = 1'b0;
    stall_exmem = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    if (rst_n && (state_q != ILLEGAL)) begin
      if (bus.mem_busy) begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        stall_idex  = 1'b1;
        stall_exmem = 1'b1;
      end else if (take_flush || (state_q == FLUSH)) begin
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
      end else if (hazard) begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        bubble_idex = 1'b1;
      end
    end
  end

  assign bus.stall_pc    = stall_pc;
  assign bus.stall_ifid  = stall_ifid;
  assign bus.bubble_idex = bubble_idex;
  assign bus.stall_idex  = stall_idex;
  assign bus.stall_exmem = stall_exmem;
  assign bus.flush_ifid  = flush_ifid;
  assign bus.flush_idex  = flush_idex;
  assign bus.sched_state = state_q;

`ifdef HAZ_SCHED_PERF_CNT_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (stall_pc && (stall_cnt_q != 16'hFFFF))   stall_cnt_q <= stall_cnt_q + 16'd1;
      if (flush_ifid && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign bus.stall_count = stall_cnt_q;
  assign bus.flush_count = flush_cnt_q;
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_id_hazard_sched.sv
// Directed bench for id_hazard_sched with FLUSH_CYCLES=2 and hand-computed expected output vectors.
// Output vector layout: {stall_pc, stall_ifid, bubble_idex, stall_idex, stall_exmem, flush_ifid, flush_idex, sched_state[1:0]}.
module tb_id_hazard_sched;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_hazard_sched_if bus();

  id_hazard_sched #(.FLUSH_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [8:0] O_IDLE = 9'b000_00_00_00;
  localparam logic [8:0] O_LU   = 9'b111_00_00_00;
  localparam logic [8:0] O_MB   = 9'b110_11_00_00;
  localparam logic [8:0] O_FL   = 9'b000_00_11_00;
  localparam logic [8:0] S_FL   = 9'd1;
  localparam logic [8:0] S_MW   = 9'd2;

  function automatic logic [8:0] outs();
    return {bus.stall_pc, bus.stall_ifid, bus.bubble_idex, bus.stall_idex, bus.stall_exmem,
            bus.flush_ifid, bus.flush_idex, bus.sched_state};
  endfunction

  // s = {load-use hazard present, ctrl_taken, mem_busy}
  task automatic drive(input logic [2:0] s);
    bus.id_valid      = 1'b1;
    bus.id_rs         = 4'd7;
    bus.id_rt         = 4'd9;
    bus.id_uses_rt    = 1'b1;
    bus.ex_valid      = 1'b1;
    bus.ex_rd         = 4'd7;
    bus.ex_mem_to_reg = s[2];
    bus.ctrl_taken    = s[1];
    bus.mem_busy      = s[0];
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(3'b110);
    #2;
    if (outs() !== O_IDLE) begin
      miscompares++;
      $display("FAIL reset_hazard_ctrl: got %b want %b", outs(), O_IDLE);
    end
    vectors++;
    drive(3'b101);
    #2;
    if (outs() !== O_IDLE) begin
      miscompares++;
      $display("FAIL reset_busy: got %b want %b", outs(), O_IDLE);
    end
    vectors++;
    next_cycle();
    rst_n = 1'b1;
    drive(3'b000);
    @(negedge clk);
    if (outs() !== O_IDLE) begin
      miscompares++;
      $display("FAIL reset_release: got %b want %b", outs(), O_IDLE);
    end
    vectors++;
    next_cycle();
  endtask

  typedef struct packed {
    logic [3:0] rs;
    logic [3:0] rt;
    logic       uses;
    logic [3:0] rd;
    logic       ld;
    logic       ev;
    logic       stall;
  } lu_vec_t;

  task automatic test_load_use();
    lu_vec_t v [7] = '{
      '{4'd3, 4'd1, 1'b0, 4'd3, 1'b1, 1'b1, 1'b1},
      '{4'd3, 4'd1, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0},
      '{4'd2, 4'd5, 1'b1, 4'd5, 1'b1, 1'b1, 1'b1},
      '{4'd2, 4'd5, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0},
      '{4'd0, 4'd0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0},
      '{4'd6, 4'd6, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0},
      '{4'd6, 4'd6, 1'b1, 4'd6, 1'b1, 1'b1, 1'b1}
    };
    for (int i = 0; i < 7; i++) begin
      drive(3'b000);
      bus.id_rs         = v[i].rs;
      bus.id_rt         = v[i].rt;
      bus.id_uses_rt    = v[i].uses;
      bus.ex_rd         = v[i].rd;
      bus.ex_mem_to_reg = v[i].ld;
      bus.ex_valid      = v[i].ev;
      @(negedge clk);
      if (outs() !== (v[i].stall ? O_LU : O_IDLE)) begin
        miscompares++;
        $display("FAIL load_use[%0d]: got %b want %b", i, outs(), v[i].stall ? O_LU : O_IDLE);
      end
      vectors++;
      next_cycle();
    end
    drive(3'b000);
  endtask

  task automatic test_flush();
    logic [2:0] stim [4] = '{3'b010, 3'b100, 3'b100, 3'b000};
    logic [8:0] exp  [4] = '{O_FL, O_FL | S_FL, O_LU, O_IDLE};
    for (int i = 0; i < 4; i++) begin
      drive(stim[i]);
      @(negedge clk);
      if (outs() !== exp[i]) begin
        miscompares++;
        $display("FAIL flush[%0d]: got %b want %b", i, outs(), exp[i]);
      end
      vectors++;
      next_cycle();
    end
  endtask

  task automatic test_reload();
    logic [2:0] stim [4] = '{3'b010, 3'b010, 3'b000, 3'b000};
    logic [8:0] exp  [4] = '{O_FL, O_FL | S_FL, O_FL | S_FL, O_IDLE};
    for (int i = 0; i < 4; i++) begin
      drive(stim[i]);
      @(negedge clk);
      if (outs() !== exp[i]) begin
        miscompares++;
        $display("FAIL reload[%0d]: got %b want %b", i, outs(), exp[i]);
      end
      vectors++;
      next_cycle();
    end
  endtask

  task automatic test_busy_pending();
    logic [2:0] stim [6] = '{3'b011, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000};
    logic [8:0] exp  [6] = '{O_MB, O_MB | S_MW, O_MB | S_MW, O_FL | S_MW, O_FL | S_FL, O_IDLE};
    for (int i = 0; i < 6; i++) begin
      drive(stim[i]);
      @(negedge clk);
      if (outs() !== exp[i]) begin
        miscompares++;
        $display("FAIL busy_pending[%0d]: got %b want %b", i, outs(), exp[i]);
      end
      vectors++;
      next_cycle();
    end
  endtask

  task automatic test_busy_in_flush();
    logic [2:0] stim [4] = '{3'b010, 3'b001, 3'b000, 3'b000};
    logic [8:0] exp  [4] = '{O_FL, O_MB | S_FL, O_IDLE | S_MW, O_IDLE};
    for (int i = 0; i < 4; i++) begin
      drive(stim[i]);
      @(negedge clk);
      if (outs() !== exp[i]) begin
        miscompares++;
        $display("FAIL busy_in_flush[%0d]: got %b want %b", i, outs(), exp[i]);
      end
      vectors++;
      next_cycle();
    end
  endtask

  task automatic test_priority();
    logic [2:0] stim [6] = '{3'b110, 3'b100, 3'b000, 3'b101, 3'b000, 3'b000};
    logic [8:0] exp  [6] = '{O_FL, O_FL | S_FL, O_IDLE, O_MB, O_IDLE | S_MW, O_IDLE};
    for (int i = 0; i < 6; i++) begin
      drive(stim[i]);
      @(negedge clk);
      if (outs() !== exp[i]) begin
        miscompares++;
        $display("FAIL priority[%0d]: got %b want %b", i, outs(), exp[i]);
      end
      vectors++;
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_op();
    logic [8:0] exp [8] = '{O_FL | S_FL, O_IDLE, O_IDLE, O_IDLE,
                            O_MB | S_MW, O_IDLE, O_IDLE, O_IDLE};
    logic [8:0] got [8];
    drive(3'b010);
    next_cycle();
    drive(3'b000);
    @(negedge clk);
    got[0] = outs();
    #1 rst_n = 1'b0;
    #1 got[1] = outs();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    got[2] = outs();
    next_cycle();
    @(negedge clk);
    got[3] = outs();
    next_cycle();
    drive(3'b011);
    next_cycle();
    drive(3'b001);
    @(negedge clk);
    got[4] = outs();
    #1 rst_n = 1'b0;
    #1 got[5] = outs();
    drive(3'b000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    got[6] = outs();
    next_cycle();
    @(negedge clk);
    got[7] = outs();
    next_cycle();
    for (int i = 0; i < 8; i++) begin
      if (got[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL reset_mid_op[%0d]: got %b want %b", i, got[i], exp[i]);
      end
      vectors++;
    end
  endtask

`ifdef HAZ_SCHED_PERF_CNT_EN
  task automatic test_perf_counters();
    rst_n = 1'b0;
    drive(3'b000);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    if (bus.stall_count !== 16'd0 || bus.flush_count !== 16'd0) begin
      miscompares++;
      $display("FAIL perf_reset: got %h/%h want 0000/0000", bus.stall_count, bus.flush_count);
    end
    vectors++;
    next_cycle();
    drive(3'b010);
    next_cycle();
    drive(3'b000);
    next_cycle();
    next_cycle();
    @(negedge clk);
    if (bus.flush_count !== 16'd2) begin
      miscompares++;
      $display("FAIL perf_flush: got %h want 0002", bus.flush_count);
    end
    vectors++;
    drive(3'b001);
    for (int i = 0; i < 70000; i++) next_cycle();
    @(negedge clk);
    if (bus.stall_count !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL perf_stall_sat: got %h want ffff", bus.stall_count);
    end
    vectors++;
    drive(3'b000);
    next_cycle();
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    drive(3'b000);
    next_cycle();
    test_reset();
    test_load_use();
    test_flush();
    test_reload();
    test_busy_pending();
    test_busy_in_flush();
    test_priority();
    test_reset_mid_op();
`ifdef HAZ_SCHED_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_hazard_sched.md
ID_HAZARD_SCHED -- requirements
Module: id_hazard_sched

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, number of cycles IF/ID and ID/EX are flushed after a taken control transfer; legal range 1..7.
REQ-002 clk  input  1  global clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 id_valid  input  1  ID stage holds a valid instruction.
REQ-005 id_rs  input  4  ID source register 1.
REQ-006 id_rt  input  4  ID source register 2, already muxed for save-word.
REQ-007 id_uses_rt  input  1  ID instruction reads id_rt.
REQ-008 ex_valid  input  1  EX stage holds a valid instruction.
REQ-009 ex_mem_to_reg  input  1  EX instruction is a load.
REQ-010 ex_rd  input  4  EX destination register.
REQ-011 ctrl_taken  input  1  taken branch, call or ret resolved in EX this cycle.
REQ-012 mem_busy  input  1  data memory not ready; whole pipeline must hold.
REQ-013 stall_pc, stall_ifid  output  1 each  hold PC and IF/ID register.
REQ-014 bubble_idex  output  1  load ID/EX with a NOP.
REQ-015 stall_idex, stall_exmem  output  1 each  hold ID/EX and EX/MEM.
REQ-016 flush_ifid, flush_idex  output  1 each  squash IF/ID and ID/EX contents.
REQ-017 sched_state  output  2  current FSM state encoding.

Function
REQ-018 FSM states SHALL be RUN=0, FLUSH=1, MEMWAIT=2; encoding 3 unused and SHALL return to RUN next cycle.
REQ-019 Load-use hazard SHALL be id_valid & ex_valid & ex_mem_to_reg & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)); register 0 SHALL never raise a hazard.
REQ-020 In RUN with hazard, no ctrl_taken, no mem_busy: stall_pc=stall_ifid=bubble_idex=1 in the same cycle (combinational, zero latency); state stays RUN.
REQ-021 In RUN with ctrl_taken and no mem_busy: flush_ifid=flush_idex=1 same cycle; load-use outputs SHALL be 0; if FLUSH_CYCLES>1 go to FLUSH with 3-bit counter = FLUSH_CYCLES-2, else stay RUN.
REQ-022 In FLUSH: flush_ifid=flush_idex=1; counter decrements each cycle; at counter 0 return to RUN; a new ctrl_taken reloads the counter to FLUSH_CYCLES-2.
REQ-023 mem_busy=1 in any state: stall_pc, stall_ifid, stall_idex, stall_exmem=1, all flush and bubble outputs 0, enter/stay MEMWAIT; FLUSH counter frozen.
REQ-024 ctrl_taken coinciding with mem_busy SHALL set a pending flag; on first cycle mem_busy=0 the flush of REQ-021 SHALL be applied from the flag, then flag cleared.
REQ-025 MEMWAIT exit (mem_busy=0) SHALL go to FLUSH if it was entered from FLUSH with counter nonzero or pending flag set, else RUN.
REQ-026 Priority: mem_busy > ctrl_taken/pending > FLUSH > load-use hazard.
REQ-027 All outputs not asserted by an active rule SHALL be 0.

Reset
REQ-028 rst_n low SHALL immediately force state RUN, counter 0, pending flag 0, perf counters 0; all outputs 0 while rst_n low.
REQ-029 Reset asserted mid-FLUSH or mid-MEMWAIT SHALL discard that operation; first cycle after release is RUN.

Configuration
REQ-030 Macro HAZ_SCHED_PERF_CNT_EN defined: outputs stall_count[15:0] and flush_count[15:0] SHALL count cycles with stall_pc=1 and flush_ifid=1 respectively, saturating at 16'hFFFF.
REQ-031 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-032 ex load to r3, ID reads rs=r3 -> stall_pc=stall_ifid=bubble_idex=1 for exactly 1 cycle; rs=r0 with ex_rd=r0 -> no stall.
REQ-033 ctrl_taken pulse, FLUSH_CYCLES=2 -> flush_ifid/flush_idex high 2 cycles, sched_state 0->1->0.
REQ-034 ctrl_taken with mem_busy high 3 cycles -> stall_* high 3 cycles, flush 0, then flush 2 cycles after mem_busy falls.
REQ-035 ctrl_taken and load-use hazard same cycle -> flush=1, bubble_idex=0, stall_pc=0.
REQ-036 rst_n low in FLUSH cycle 1 -> outputs 0 asynchronously, state RUN after release.
REQ-037 With HAZ_SCHED_PERF_CNT_EN: 70000 stall cycles -> stall_count=16'hFFFF.
